fetch_controller: RTL

Sequencing controller for the fetch stage. It owns the fetch stage's enable, PC-select and new-PC inputs, plus the fetch/decode and decode/execute flush lines. It arbitrates PC redirects from execute (branch) and decode (jump) against hazard stalls, instruction-memory wait, and halt/resume requests, and holds a pending redirect across memory wait. It also keeps a saturating stall-cycle counter.

---
 rtl/fetch_controller_if.sv | 34 +++
 rtl/fetch_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch sequencing bundle between controller and pipeline/requesters
interface fetch_controller_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump_valid;
    logic [WIDTH-1:0] jump_target;
    logic             hazard_stall;
    logic             imem_ready;
    logic             halt_request;
    logic             resume;

    logic                 pc_enable;
    logic                 pc_select;
    logic [WIDTH-1:0]     new_pc;
    logic                 flush_fd;
    logic                 flush_de;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        input  branch_taken, branch_target, jump_valid, jump_target,
               hazard_stall, imem_ready, halt_request, resume,
        output pc_enable, pc_select, new_pc, flush_fd, flush_de, state, stall_cycles
    );

    modport slave (
        output branch_taken, branch_target, jump_valid, jump_target,
               hazard_stall, imem_ready, halt_request, resume,
        input  pc_enable, pc_select, new_pc, flush_fd, flush_de, state, stall_cycles
    );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: redirect arbitration, memory wait, halt, stall count
module fetch_controller #(
    parameter int WIDTH        = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic              clock,
    input  logic              reset,
    fetch_controller_if.master bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [3:0] RLOAD = 4'(FLUSH_CYCLES - 1);
    // With a single flush cycle the redirect cycle itself is enough; skip REDIRECT.
    localparam state_t AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;

    state_t               cur, nxt;
    logic                 pending_valid, pending_valid_nxt;
    logic [WIDTH-1:0]     pending_target, pending_target_nxt;
    logic [3:0]           rcnt, rcnt_nxt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    logic             en, sel, ffd, fde;
    logic [WIDTH-1:0] npc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur            <= RUN;
            pending_valid  <= 1'b0;
            pending_target <= '0;
            rcnt           <= '0;
            stall_cnt      <= '0;
        end else begin
            cur            <= nxt;
            pending_valid  <= pending_valid_nxt;
            pending_target <= pending_target_nxt;
            rcnt           <= rcnt_nxt;
            if (!en && cur != HALTED && stall_cnt != {CNT_WIDTH{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt                = cur;
        pending_valid_nxt  = pending_valid;
        pending_target_nxt = pending_target;
        rcnt_nxt           = rcnt;
        en  = 1'b1;
        sel = 1'b0;
        npc = '0;
        ffd = 1'b0;
        fde = 1'b0;
        unique case (cur)
            RUN: begin
                if (bus.branch_taken) begin
                    sel = 1'b1;
                    npc = bus.branch_target;
                    ffd = 1'b1;
                    fde = 1'b1;
                    if (bus.imem_ready) begin
                        nxt      = AFTER_REDIRECT;
                        rcnt_nxt = RLOAD;
                    end else begin
                        en                 = 1'b0;
                        pending_valid_nxt  = 1'b1;
                        pending_target_nxt = bus.branch_target;
                        nxt                = WAIT_MEM;
                    end
                end else if (bus.jump_valid) begin
                    sel = 1'b1;
                    npc = bus.jump_target;
                    ffd = 1'b1;
                end else if (bus.halt_request) begin
                    en  = 1'b0;
                    ffd = 1'b1;
                    nxt = HALTED;
                end else if (bus.hazard_stall) begin
                    en  = 1'b0;
                    fde = 1'b1;
                end else if (!bus.imem_ready) begin
                    en  = 1'b0;
                    nxt = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (bus.branch_taken) begin
                    pending_valid_nxt  = 1'b1;
                    pending_target_nxt = bus.branch_target;
                    ffd = 1'b1;
                    fde = 1'b1;
                end
                if (!bus.imem_ready) begin
                    en = 1'b0;
                end else if (pending_valid || bus.branch_taken) begin
                    // A branch arriving on the ready cycle is newer than anything pending.
                    sel               = 1'b1;
                    npc               = bus.branch_taken ? bus.branch_target : pending_target;
                    pending_valid_nxt = 1'b0;
                    nxt               = AFTER_REDIRECT;
                    rcnt_nxt          = RLOAD;
                end else begin
                    nxt = RUN;
                end
            end
            REDIRECT: begin
                ffd = 1'b1;
                en  = bus.imem_ready;
                if (bus.imem_ready) begin
                    if (rcnt <= 4'd1) begin
                        rcnt_nxt = '0;
                        nxt      = RUN;
                    end else begin
                        rcnt_nxt = rcnt - 4'd1;
                    end
                end
            end
            HALTED: begin
                en  = 1'b0;
                ffd = 1'b1;
                if (bus.resume && !bus.halt_request)
                    nxt = RUN;
            end
            default: nxt = RUN;
        endcase
    end

    assign bus.pc_enable    = reset & en;
    assign bus.pc_select    = reset & sel;
    assign bus.new_pc       = reset ? npc : '0;
    assign bus.flush_fd     = reset & ffd;
    assign bus.flush_de     = reset & fde;
    assign bus.state        = reset ? cur : 2'd0;
    assign bus.stall_cycles = reset ? stall_cnt : '0;
endmodule
